bp_gshare_btb: RTL and testbench

Parametrised branch predictor at the IF stage of the superscalar pipeline; successor to `branch_predictor`. Each cycle it predicts direction and target for `SCALAR` fetch slots from a tagged BTB and a table of 2-bit counters. The table is indexed by NPC alone (bimodal) or by NPC XOR global history (gshare). It is trained non-speculatively from up to `SCALAR` retiring branches per cycle, reported by the ROB.

---
 rtl/bp_pkg.sv | 43 ++++
 rtl/bp_btb.sv | 62 ++++++
 rtl/bp_gshare_btb.sv | 107 ++++++++++
 tb/tb_bp_gshare_btb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the gshare/bimodal branch predictor: counter
// encodings, saturating counter update and NPC field extraction.
package bp_pkg;

    localparam int NPC_W = 64;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] sat2(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

    // BTB index: instruction-aligned low bits of the NPC.
    function automatic logic [31:0] bp_bidx(input logic [NPC_W-1:0] npc, input int unsigned idx_w);
        logic [NPC_W-1:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((npc >> 2) & mask);
    endfunction

    // BTB tag: the NPC bits just above the index field.
    function automatic logic [31:0] bp_tag(input logic [NPC_W-1:0] npc, input int unsigned idx_w,
                                           input int unsigned tag_w);
        logic [NPC_W-1:0] mask;
        mask = (64'd1 << tag_w) - 64'd1;
        return 32'((npc >> (idx_w + 2)) & mask);
    endfunction

    // PHT index: the BTB index, optionally hashed with the zero-extended history.
    function automatic logic [31:0] bp_pidx(input logic [NPC_W-1:0] npc, input logic [31:0] ghr,
                                            input logic use_hist, input int unsigned idx_w);
        logic [31:0] bi;
        bi = bp_bidx(npc, idx_w);
        return use_hist ? (bi ^ ghr) : bi;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Tagged branch target buffer: SCALAR combinational lookups, SCALAR
// slot-ordered writes where the higher slot wins on an index collision.
module bp_btb
    import bp_pkg::*;
#(
    parameter int SCALAR   = 2,
    parameter int PRED_IDX = 5,
    parameter int TAG_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SCALAR*PRED_IDX-1:0] rd_idx_i,
    input  logic [SCALAR*TAG_W-1:0]    rd_tag_i,
    output logic [SCALAR-1:0]          rd_hit_o,
    output logic [SCALAR*NPC_W-1:0]    rd_target_o,
    input  logic [SCALAR-1:0]          wr_en_i,
    input  logic [SCALAR*PRED_IDX-1:0] wr_idx_i,
    input  logic [SCALAR*TAG_W-1:0]    wr_tag_i,
    input  logic [SCALAR*NPC_W-1:0]    wr_target_i
);

    localparam int ENTRIES = 1 << PRED_IDX;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [NPC_W-1:0]   target_q [ENTRIES];

    // Valid bits: cleared by reset, set by any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < SCALAR; k++) begin
                if (wr_en_i[k]) begin
                    valid_q[wr_idx_i[k*PRED_IDX +: PRED_IDX]] <= 1'b1;
                end
            end
        end
    end

    // Tag/target storage, not reset; later slots overwrite earlier ones.
    always_ff @(posedge clk) begin
        for (int k = 0; k < SCALAR; k++) begin
            if (wr_en_i[k]) begin
                tag_q[wr_idx_i[k*PRED_IDX +: PRED_IDX]]    <= wr_tag_i[k*TAG_W +: TAG_W];
                target_q[wr_idx_i[k*PRED_IDX +: PRED_IDX]] <= wr_target_i[k*NPC_W +: NPC_W];
            end
        end
    end

    // Per-slot lookup against registered contents (no write bypass).
    always_comb begin
        rd_hit_o    = '0;
        rd_target_o = '0;
        for (int k = 0; k < SCALAR; k++) begin
            rd_hit_o[k] = valid_q[rd_idx_i[k*PRED_IDX +: PRED_IDX]] &&
                          (tag_q[rd_idx_i[k*PRED_IDX +: PRED_IDX]] == rd_tag_i[k*TAG_W +: TAG_W]);
            rd_target_o[k*NPC_W +: NPC_W] = target_q[rd_idx_i[k*PRED_IDX +: PRED_IDX]];
        end
    end

endmodule

// File: rtl/bp_gshare_btb.sv
// Superscalar IF-stage branch predictor: tagged BTB plus a 2-bit counter
// table indexed bimodally or by NPC xor global history, trained at retire.
module bp_gshare_btb
    import bp_pkg::*;
#(
    parameter int SCALAR   = 2,
    parameter int PRED_IDX = 5,
    parameter int TAG_W    = 8,
    parameter int HIST_W   = 4,
    parameter int USE_HIST = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SCALAR*NPC_W-1:0] IF_NPC,
    input  logic [SCALAR-1:0]       ROB_br_en,
    input  logic [SCALAR*NPC_W-1:0] ROB_NPC,
    input  logic [SCALAR-1:0]       ROB_taken,
    input  logic [SCALAR*NPC_W-1:0] ROB_taken_address,
    output logic [SCALAR*NPC_W-1:0] paddress,
    output logic [SCALAR-1:0]       ptaken
);

    localparam int   ENTRIES = 1 << PRED_IDX;
    localparam logic HASH    = (USE_HIST != 0);

    logic [ENTRIES-1:0][1:0] pht_q, pht_d;
    logic [HIST_W-1:0]       ghr_q, ghr_d;
    logic [PRED_IDX-1:0]     upd_pi;

    logic [SCALAR*PRED_IDX-1:0]  rd_idx, wr_idx;
    logic [SCALAR*TAG_W-1:0]     rd_tag, wr_tag;
    logic [SCALAR-1:0]           rd_hit, wr_en;
    logic [SCALAR*NPC_W-1:0]     rd_target;
    logic [SCALAR-1:0][PRED_IDX-1:0] pred_pi;

    // BTB address fields for lookup and training; reset-cycle writes are dropped.
    always_comb begin
        rd_idx = '0;
        rd_tag = '0;
        wr_idx = '0;
        wr_tag = '0;
        wr_en  = ROB_br_en & ROB_taken & {SCALAR{~reset}};
        for (int k = 0; k < SCALAR; k++) begin
            rd_idx[k*PRED_IDX +: PRED_IDX] = PRED_IDX'(bp_bidx(IF_NPC[k*NPC_W +: NPC_W], PRED_IDX));
            rd_tag[k*TAG_W +: TAG_W]       = TAG_W'(bp_tag(IF_NPC[k*NPC_W +: NPC_W], PRED_IDX, TAG_W));
            wr_idx[k*PRED_IDX +: PRED_IDX] = PRED_IDX'(bp_bidx(ROB_NPC[k*NPC_W +: NPC_W], PRED_IDX));
            wr_tag[k*TAG_W +: TAG_W]       = TAG_W'(bp_tag(ROB_NPC[k*NPC_W +: NPC_W], PRED_IDX, TAG_W));
        end
    end

    bp_btb #(
        .SCALAR   (SCALAR),
        .PRED_IDX (PRED_IDX),
        .TAG_W    (TAG_W)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (rd_idx),
        .rd_tag_i    (rd_tag),
        .rd_hit_o    (rd_hit),
        .rd_target_o (rd_target),
        .wr_en_i     (wr_en),
        .wr_idx_i    (wr_idx),
        .wr_tag_i    (wr_tag),
        .wr_target_i (ROB_taken_address)
    );

    // Slot-ordered training: each retire sees history shifted by older slots.
    always_comb begin
        pht_d  = pht_q;
        ghr_d  = ghr_q;
        upd_pi = '0;
        for (int k = 0; k < SCALAR; k++) begin
            if (ROB_br_en[k]) begin
                upd_pi         = PRED_IDX'(bp_pidx(ROB_NPC[k*NPC_W +: NPC_W], 32'(ghr_d), HASH, PRED_IDX));
                pht_d[upd_pi]  = sat2(pht_d[upd_pi], ROB_taken[k]);
                ghr_d          = HIST_W'({ghr_d, ROB_taken[k]});
            end
        end
    end

    // Counter table and global history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pht_q <= {ENTRIES{WNT}};
            ghr_q <= '0;
        end else begin
            pht_q <= pht_d;
            ghr_q <= ghr_d;
        end
    end

    // Combinational prediction from registered state; forced not-taken in reset.
    always_comb begin
        pred_pi  = '0;
        ptaken   = '0;
        paddress = IF_NPC;
        for (int k = 0; k < SCALAR; k++) begin
            pred_pi[k] = PRED_IDX'(bp_pidx(IF_NPC[k*NPC_W +: NPC_W], 32'(ghr_q), HASH, PRED_IDX));
            ptaken[k]  = !reset && rd_hit[k] && pht_q[pred_pi[k]][1];
            if (ptaken[k]) begin
                paddress[k*NPC_W +: NPC_W] = rd_target[k*NPC_W +: NPC_W];
            end
        end
    end

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Directed bench for bp_gshare_btb: a bimodal instance driven from a vector
// table and a gshare instance exercised by hand-written history sequences.
module tb_bp_gshare_btb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [127:0] IF_NPC, ROB_NPC, ROB_taken_address;
    logic [1:0]   ROB_br_en, ROB_taken;
    logic [127:0] pa_b, pa_g;
    logic [1:0]   pt_b, pt_g;

    int checks   = 0;
    int failures = 0;

    bp_gshare_btb #(.SCALAR(2), .PRED_IDX(5), .TAG_W(8), .HIST_W(4), .USE_HIST(0)) u_bim (
        .clk(clk), .reset(reset), .IF_NPC(IF_NPC), .ROB_br_en(ROB_br_en), .ROB_NPC(ROB_NPC),
        .ROB_taken(ROB_taken), .ROB_taken_address(ROB_taken_address),
        .paddress(pa_b), .ptaken(pt_b));

    bp_gshare_btb #(.SCALAR(2), .PRED_IDX(5), .TAG_W(8), .HIST_W(4), .USE_HIST(1)) u_gsh (
        .clk(clk), .reset(reset), .IF_NPC(IF_NPC), .ROB_br_en(ROB_br_en), .ROB_NPC(ROB_NPC),
        .ROB_taken(ROB_taken), .ROB_taken_address(ROB_taken_address),
        .paddress(pa_g), .ptaken(pt_g));

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  en, tk;
        logic [63:0] rn0, ra0, rn1, ra1, if0, if1;
        logic [1:0]  ept;
        logic [63:0] epa0, epa1;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] A  = 64'h104;  // bi=1 tag=0x02
    localparam logic [63:0] B  = 64'h200;
    localparam logic [63:0] C  = 64'h904;  // bi=1 tag=0x12
    localparam logic [63:0] D  = 64'h400;
    localparam logic [63:0] E  = 64'h500;
    localparam logic [63:0] F  = 64'h108;  // bi=2
    localparam logic [63:0] Z  = 64'h0;

    task automatic add(input string name, input logic rst, input logic [1:0] en, input logic [1:0] tk,
                       input logic [63:0] rn0, input logic [63:0] ra0, input logic [63:0] rn1,
                       input logic [63:0] ra1, input logic [63:0] if0, input logic [63:0] if1,
                       input logic [1:0] ept, input logic [63:0] epa0, input logic [63:0] epa1);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.tk = tk;
        v.rn0 = rn0; v.ra0 = ra0; v.rn1 = rn1; v.ra1 = ra1; v.if0 = if0; v.if1 = if1;
        v.ept = ept; v.epa0 = epa0; v.epa1 = epa1;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic rst, input logic [1:0] en, input logic [1:0] tk,
                         input logic [63:0] rn0, input logic [63:0] ra0, input logic [63:0] rn1,
                         input logic [63:0] ra1, input logic [63:0] if0, input logic [63:0] if1);
        @(negedge clk);
        reset             = rst;
        ROB_br_en         = en;
        ROB_taken         = tk;
        ROB_NPC           = {rn1, rn0};
        ROB_taken_address = {ra1, ra0};
        IF_NPC            = {if1, if0};
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] apt, input logic [127:0] apa,
                         input logic [1:0] ept, input logic [63:0] epa0, input logic [63:0] epa1);
        checks++;
        if (apt !== ept || apa[63:0] !== epa0 || apa[127:64] !== epa1) begin
            failures++;
            $display("FAIL %s: got ptaken=%b pa0=%h pa1=%h, expected ptaken=%b pa0=%h pa1=%h",
                     name, apt, apa[63:0], apa[127:64], ept, epa0, epa1);
        end
    endtask

    initial begin
        reset = 1'b1; ROB_br_en = '0; ROB_taken = '0;
        ROB_NPC = '0; ROB_taken_address = '0; IF_NPC = '0;

        // Bimodal table: each row's prediction reflects state before its own retires.
        add("reset_hold",     1, 2'b00, 2'b00, Z, Z, Z, Z, A, B, 2'b00, A, B);
        add("after_reset",    0, 2'b00, 2'b00, Z, Z, Z, Z, A, B, 2'b00, A, B);
        add("first_taken",    0, 2'b01, 2'b01, A, D, Z, Z, A, B, 2'b00, A, B);
        add("tag_miss_alias", 0, 2'b01, 2'b01, A, D, Z, Z, C, A, 2'b10, C, D);
        add("strong_taken",   0, 2'b01, 2'b00, A, Z, Z, Z, A, B, 2'b01, D, B);
        add("weak_taken",     0, 2'b01, 2'b00, A, Z, Z, Z, A, B, 2'b01, D, B);
        add("back_to_wnt",    0, 2'b00, 2'b00, Z, Z, Z, Z, A, B, 2'b00, A, B);
        add("reset_again",    1, 2'b00, 2'b00, Z, Z, Z, Z, A, B, 2'b00, A, B);
        add("dual_pre",       0, 2'b11, 2'b11, A, D, A, E, A, B, 2'b00, A, B);
        add("dual_taken",     0, 2'b11, 2'b00, A, Z, A, Z, A, A, 2'b11, E, E);
        add("dual_not_taken", 0, 2'b01, 2'b00, A, Z, Z, Z, A, A, 2'b00, A, A);
        add("snt_floor",      0, 2'b01, 2'b01, A, E, Z, Z, A, B, 2'b00, A, B);
        add("climb_wnt",      0, 2'b01, 2'b01, A, E, Z, Z, A, B, 2'b00, A, B);
        add("climbed_wt",     0, 2'b00, 2'b00, Z, Z, Z, Z, A, B, 2'b01, E, B);
        add("to_st",          0, 2'b01, 2'b01, A, E, Z, Z, A, B, 2'b01, E, B);
        add("st_hold",        0, 2'b01, 2'b01, A, E, Z, Z, A, B, 2'b01, E, B);
        add("st_down",        0, 2'b01, 2'b00, A, Z, Z, Z, A, B, 2'b01, E, B);
        add("wt_after_down",  0, 2'b00, 2'b00, Z, Z, Z, Z, A, B, 2'b01, E, B);
        add("reset_w_update", 1, 2'b01, 2'b01, A, 64'h700, Z, Z, A, B, 2'b00, A, B);
        add("post_reset",     0, 2'b00, 2'b00, Z, Z, Z, Z, A, B, 2'b00, A, B);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].tk, vecs[i].rn0, vecs[i].ra0,
                  vecs[i].rn1, vecs[i].ra1, vecs[i].if0, vecs[i].if1);
            check(vecs[i].name, pt_b, pa_b, vecs[i].ept, vecs[i].epa0, vecs[i].epa1);
        end

        // Gshare: one taken retire leaves PHT[1]=WT, ghr=0001; fetch of 0x104 reads PHT[0].
        drive(1, 2'b00, 2'b00, Z, Z, Z, Z, A, B);
        drive(0, 2'b01, 2'b01, A, D, Z, Z, A, B);
        drive(0, 2'b00, 2'b00, Z, Z, Z, Z, A, B);
        check("gsh_hit_pi0_wnt", pt_g, pa_g, 2'b00, A, B);

        // Four not-taken retires (two per cycle) shift ghr back to 0000; fetch reads PHT[1].
        drive(0, 2'b11, 2'b00, F, Z, F, Z, A, B);
        drive(0, 2'b11, 2'b00, F, Z, F, Z, A, B);
        drive(0, 2'b00, 2'b00, Z, Z, Z, Z, A, B);
        check("gsh_ghr_wrap", pt_g, pa_g, 2'b01, D, B);

        // Make ghr nonzero, then reset together with a taken retire.
        drive(0, 2'b01, 2'b01, F, 64'h800, Z, Z, A, B);
        drive(1, 2'b01, 2'b01, A, 64'h700, Z, Z, A, B);
        check("gsh_reset_hold", pt_g, pa_g, 2'b00, A, B);
        drive(0, 2'b01, 2'b01, A, D, Z, Z, A, B);
        check("gsh_post_reset_miss", pt_g, pa_g, 2'b00, A, B);
        // With ghr cleared the retire trained PHT[1]; four not-takens return ghr to 0.
        drive(0, 2'b11, 2'b00, F, Z, F, Z, A, B);
        drive(0, 2'b11, 2'b00, F, Z, F, Z, A, B);
        drive(0, 2'b00, 2'b00, Z, Z, Z, Z, A, B);
        check("gsh_ghr_cleared", pt_g, pa_g, 2'b01, D, B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
